// File: rtl/hash_result_scan_pkg.sv
// Shared definitions for the hash result scanner.
//   state_e   : scanner FSM states
//   NO_HIT    : first_hit value when no word beat the target
//   OFS_*     : word offsets inside the 4-word summary record
package hash_result_scan_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StDone
   } state_e;

   localparam logic [31:0] NO_HIT = 32'hFFFF_FFFF;

   localparam logic [1:0] OFS_MIN   = 2'd0;
   localparam logic [1:0] OFS_IDX   = 2'd1;
   localparam logic [1:0] OFS_CNT   = 2'd2;
   localparam logic [1:0] OFS_FIRST = 2'd3;

endpackage

// File: rtl/hash_result_scan_if.sv
// Shared single-port memory bus between the scanner and the memory.
//   mem_clk        : memory clock (copy of the scanner clock)
//   mem_we         : write enable
//   mem_addr       : 16-bit word address
//   mem_write_data : write data
//   mem_read_data  : read data, valid one cycle after the address
interface hash_result_scan_if;

   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output mem_clk,
      output mem_we,
      output mem_addr,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_clk,
      input  mem_we,
      input  mem_addr,
      input  mem_write_data,
      output mem_read_data
   );

endinterface

// File: rtl/hash_result_scan_scan_compare_unit.sv
// Running minimum / hit tracker for the hash result scanner.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart tracking (start of a new scan)
//   valid      : word/idx carry a hash word to evaluate this cycle
//   word, idx  : hash word and its nonce index
//   target     : difficulty target; word < target is a hit
//   min_word, min_idx : smallest word so far and its index (lowest index on ties)
//   hit_cnt    : saturating hit count
//   first_hit  : index of first hit, zero-extended, or NO_HIT
module hash_result_scan_scan_compare_unit #(
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             valid,
   input  logic [31:0]      word,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      target,
   output logic [31:0]      min_word,
   output logic [IDX_W-1:0] min_idx,
   output logic [IDX_W-1:0] hit_cnt,
   output logic [31:0]      first_hit
);
   import hash_result_scan_pkg::*;

   logic [31:0]      min_q, min_d;
   logic [IDX_W-1:0] min_idx_q, min_idx_d;
   logic [IDX_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [31:0]      first_hit_q, first_hit_d;

   always_comb begin
      min_d       = min_q;
      min_idx_d   = min_idx_q;
      hit_cnt_d   = hit_cnt_q;
      first_hit_d = first_hit_q;
      if (clear) begin
         min_d       = NO_HIT;
         min_idx_d   = '0;
         hit_cnt_d   = '0;
         first_hit_d = NO_HIT;
      end else if (valid) begin
         // Strict compare: equal words never displace an earlier index.
         if (word < min_q) begin
            min_d     = word;
            min_idx_d = idx;
         end
         if (word < target) begin
            // Count saturates, so zero only before the first hit.
            if (hit_cnt_q == '0) begin
               first_hit_d = {{(32-IDX_W){1'b0}}, idx};
            end
            if (hit_cnt_q != '1) begin
               hit_cnt_d = hit_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_q       <= NO_HIT;
         min_idx_q   <= '0;
         hit_cnt_q   <= '0;
         first_hit_q <= NO_HIT;
      end else begin
         min_q       <= min_d;
         min_idx_q   <= min_idx_d;
         hit_cnt_q   <= hit_cnt_d;
         first_hit_q <= first_hit_d;
      end
   end

   assign min_word  = min_q;
   assign min_idx   = min_idx_q;
   assign hit_cnt   = hit_cnt_q;
   assign first_hit = first_hit_q;

endmodule

// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES hash words from memory, tracks the minimum and target hits,
// writes a 4-word summary record {min, min_idx, hit_cnt, first_hit} and pulses done.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a scan (only honoured when idle)
//   hash_addr   : address of nonce 0's hash word
//   result_addr : address of the summary record
//   target      : difficulty target
//   done        : one-cycle pulse after the record is written
//   found       : last scan had at least one hit
//   best_nonce  : index of the minimum word of the last scan
//   mem         : shared memory bus (master side)
module hash_result_scan #(
   parameter int unsigned NUM_NONCES = 16,
   parameter int unsigned IDX_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      hash_addr,
   input  logic [15:0]      result_addr,
   input  logic [31:0]      target,
   output logic             done,
   output logic             found,
   output logic [IDX_W-1:0] best_nonce,
   hash_result_scan_if.master mem
);
   import hash_result_scan_pkg::*;

   // READ-cycle counter values: last address issue and last word arrival.
   localparam logic [IDX_W:0] LAST_ADDR_CNT = (IDX_W+1)'(NUM_NONCES - 1);
   localparam logic [IDX_W:0] LAST_CNT      = (IDX_W+1)'(NUM_NONCES);

   state_e           state_q, state_d;
   logic [IDX_W:0]   rd_cnt_q, rd_cnt_d;
   logic [1:0]       wr_ofs_q, wr_ofs_d;
   logic [15:0]      mem_addr_q, mem_addr_d;
   logic             mem_we_q, mem_we_d;
   logic             done_q, done_d;
   logic             found_q, found_d;
   logic [IDX_W-1:0] best_nonce_q, best_nonce_d;
   logic [15:0]      result_addr_q, result_addr_d;
   logic [31:0]      target_q, target_d;

   logic             scan_clear;
   logic             scan_valid;
   logic [IDX_W-1:0] scan_idx;
   logic [31:0]      min_word;
   logic [IDX_W-1:0] min_idx;
   logic [IDX_W-1:0] hit_cnt;
   logic [31:0]      first_hit;
   logic [31:0]      write_data;

   // Read data lags the address by one cycle, so READ cycle c carries word c-1.
   assign scan_clear = (state_q == StIdle) && start;
   assign scan_valid = (state_q == StRead) && (rd_cnt_q != '0);
   assign scan_idx   = IDX_W'(rd_cnt_q - 1'b1);

   hash_result_scan_scan_compare_unit #(
      .IDX_W (IDX_W)
   ) u_scan_compare_unit (
      .clk       (clk),
      .reset     (reset),
      .clear     (scan_clear),
      .valid     (scan_valid),
      .word      (mem.mem_read_data),
      .idx       (scan_idx),
      .target    (target_q),
      .min_word  (min_word),
      .min_idx   (min_idx),
      .hit_cnt   (hit_cnt),
      .first_hit (first_hit)
   );

   always_comb begin
      state_d       = state_q;
      rd_cnt_d      = rd_cnt_q;
      wr_ofs_d      = wr_ofs_q;
      mem_addr_d    = mem_addr_q;
      mem_we_d      = mem_we_q;
      done_d        = 1'b0;
      found_d       = found_q;
      best_nonce_d  = best_nonce_q;
      result_addr_d = result_addr_q;
      target_d      = target_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               result_addr_d = result_addr;
               target_d      = target;
               mem_addr_d    = hash_addr;
               mem_we_d      = 1'b0;
               found_d       = 1'b0;
               rd_cnt_d      = '0;
               state_d       = StRead;
            end
         end
         StRead: begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q < LAST_ADDR_CNT) begin
               mem_addr_d = mem_addr_q + 16'd1;
            end
            if (rd_cnt_q == LAST_CNT) begin
               wr_ofs_d   = OFS_MIN;
               mem_we_d   = 1'b1;
               mem_addr_d = result_addr_q;
               state_d    = StWrite;
            end
         end
         StWrite: begin
            if (wr_ofs_q == OFS_FIRST) begin
               mem_we_d     = 1'b0;
               found_d      = (hit_cnt != '0);
               best_nonce_d = min_idx;
               done_d       = 1'b1;
               state_d      = StDone;
            end else begin
               wr_ofs_d   = wr_ofs_q + 2'd1;
               mem_addr_d = result_addr_q + {14'd0, wr_ofs_d};
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      write_data = '0;
      if (state_q == StWrite) begin
         unique case (wr_ofs_q)
            OFS_MIN:   write_data = min_word;
            OFS_IDX:   write_data = {{(32-IDX_W){1'b0}}, min_idx};
            OFS_CNT:   write_data = {{(32-IDX_W){1'b0}}, hit_cnt};
            OFS_FIRST: write_data = first_hit;
            default:   write_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         rd_cnt_q      <= '0;
         wr_ofs_q      <= '0;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         best_nonce_q  <= '0;
         result_addr_q <= '0;
         target_q      <= '0;
      end else begin
         state_q       <= state_d;
         rd_cnt_q      <= rd_cnt_d;
         wr_ofs_q      <= wr_ofs_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         done_q        <= done_d;
         found_q       <= found_d;
         best_nonce_q  <= best_nonce_d;
         result_addr_q <= result_addr_d;
         target_q      <= target_d;
      end
   end

   assign mem.mem_clk        = clk;
   assign mem.mem_we         = mem_we_q;
   assign mem.mem_addr       = mem_addr_q;
   assign mem.mem_write_data = write_data;

   assign done       = done_q;
   assign found      = found_q;
   assign best_nonce = best_nonce_q;

endmodule

// File: tb/tb_hash_result_scan.sv
module tb_hash_result_scan;
   import hash_result_scan_pkg::*;

   localparam int unsigned N     = 16;
   localparam int unsigned IDX_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [15:0]      hash_addr;
   logic [15:0]      result_addr;
   logic [31:0]      target;
   logic             done;
   logic             found;
   logic [IDX_W-1:0] best_nonce;

   hash_result_scan_if bus ();

   hash_result_scan #(
      .NUM_NONCES (N),
      .IDX_W      (IDX_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .hash_addr   (hash_addr),
      .result_addr (result_addr),
      .target      (target),
      .done        (done),
      .found       (found),
      .best_nonce  (best_nonce),
      .mem         (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read single-port memory model.
   logic [31:0] mem [0:65535];
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_addr];
   end

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  errors   = 0;
   int  wr_cnt   = 0;
   int  done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every memory write must match the next expected record word.
   wr_t got;
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (bus.mem_we === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_write observed addr=%h data=%h expected none",
                   bus.mem_addr, bus.mem_write_data);
         end else begin
            got = exp_q.pop_front();
            check("wr_addr", {16'h0, bus.mem_addr}, {16'h0, got.addr});
            check("wr_data", bus.mem_write_data, got.data);
         end
      end
   end

   // Reference model: computes the record from memory contents and queues it.
   task automatic push_expect(input logic [15:0] ha, input logic [15:0] ra,
                              input logic [31:0] tg, output logic exp_found,
                              output logic [IDX_W-1:0] exp_best);
      logic [31:0] mn  = 32'hFFFF_FFFF;
      logic [31:0] mi  = 0;
      logic [31:0] cnt = 0;
      logic [31:0] fh  = 32'hFFFF_FFFF;
      logic [31:0] w;
      logic [15:0] a;
      for (int k = 0; k < N; k++) begin
         a = ha + 16'(k);
         w = mem[a];
         if (w < mn) begin
            mn = w;
            mi = k;
         end
         if (w < tg) begin
            if (cnt == 0) fh = k;
            if (cnt < 255) cnt++;
         end
      end
      exp_q.push_back('{addr: ra,         data: mn});
      exp_q.push_back('{addr: ra + 16'd1, data: mi});
      exp_q.push_back('{addr: ra + 16'd2, data: cnt});
      exp_q.push_back('{addr: ra + 16'd3, data: fh});
      exp_found = (cnt != 0);
      exp_best  = mi[IDX_W-1:0];
   endtask

   task automatic run_scan(input string name, input logic [15:0] ha, input logic [15:0] ra,
                           input logic [31:0] tg, input bit poke);
      logic             ef;
      logic [IDX_W-1:0] eb;
      int               cyc;
      push_expect(ha, ra, tg, ef, eb);
      wr_cnt   = 0;
      done_cnt = 0;
      @(negedge clk);
      hash_addr   = ha;
      result_addr = ra;
      target      = tg;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = (poke && (cyc == 5 || cyc == 19 || cyc == 22)) ? 1'b1 : 1'b0;
      end
      check({name, "_latency"}, 32'(cyc), 32'd22);
      check({name, "_found"}, {31'h0, found}, {31'h0, ef});
      check({name, "_best"}, {24'h0, best_nonce}, {24'h0, eb});
      @(negedge clk);
      start = 1'b0;
      check({name, "_done_width"}, {31'h0, done}, 32'h0);
      repeat (5) @(negedge clk);
      check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({name, "_wr_cnt"}, 32'(wr_cnt), 32'd4);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset       = 1'b0;
      start       = 1'b0;
      hash_addr   = '0;
      result_addr = '0;
      target      = '0;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_found", {31'h0, found}, 32'h0);
      check("rst_best", {24'h0, best_nonce}, 32'h0);
      check("rst_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_addr", {16'h0, bus.mem_addr}, 32'h0);
      check("rst_wdata", bus.mem_write_data, 32'h0);
      check("mem_clk_low", {31'h0, bus.mem_clk}, {31'h0, clk});
      @(negedge clk);
      reset = 1'b0;

      // Descending words, no hits: min is the last word.
      for (int k = 0; k < N; k++) mem[16'h0000 + k] = 32'h0001_0000 - k;
      run_scan("desc", 16'h0000, 16'h1000, 32'h0000_0001, 1'b0);

      // Two hits among all-ones words.
      for (int k = 0; k < N; k++) mem[16'h0100 + k] = 32'hFFFF_FFFF;
      mem[16'h0105] = 32'h0000_0010;
      mem[16'h0109] = 32'h0000_0008;
      run_scan("two_hits", 16'h0100, 16'h1010, 32'h0000_0100, 1'b0);

      // All equal words: tie keeps index 0, every word a hit.
      for (int k = 0; k < N; k++) mem[16'h0200 + k] = 32'h1234_5678;
      run_scan("ties", 16'h0200, 16'h1020, 32'h1234_5679, 1'b0);

      // Target 0 with random words, start poked during READ/WRITE/DONE.
      for (int k = 0; k < N; k++) mem[16'h0300 + k] = $urandom;
      run_scan("tgt0_poke", 16'h0300, 16'h1030, 32'h0000_0000, 1'b1);

      // Address wrap FFF8..0007.
      for (int k = 0; k < N; k++) mem[16'(16'hFFF8 + k)] = 32'h0000_0500 - 32'(k * 16);
      mem[16'h0004] = 32'h0000_0003;
      run_scan("wrap", 16'hFFF8, 16'h8000, 32'h0000_0480, 1'b0);

      // Reset during the 10th READ cycle aborts the scan.
      wr_cnt   = 0;
      done_cnt = 0;
      @(negedge clk);
      hash_addr   = 16'h0100;
      result_addr = 16'h2000;
      target      = 32'h0000_0100;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_we", {31'h0, bus.mem_we}, 32'h0);
      check("mid_rst_addr", {16'h0, bus.mem_addr}, 32'h0);
      check("mid_rst_found", {31'h0, found}, 32'h0);
      check("mid_rst_best", {24'h0, best_nonce}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt), 32'd0);
      check("mid_rst_no_write", 32'(wr_cnt), 32'd0);
      run_scan("after_rst", 16'h0100, 16'h2000, 32'h0000_0100, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
